// File: rtl/cache_hierarchy.sv
// Two-level direct-mapped cache lookup controller.
// Holds the L1/L2 tag+valid arrays, serves one request at a time, models
// level-dependent latency, promotes L2 hits into L1, fills both levels on a
// miss, supports a whole-cache flush and keeps saturating outcome counters.
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready;
// req_addr is sampled on that edge. req_ready is high only in IDLE with no
// flush requested or pending. The response is a one-cycle resp_valid strobe
// with exactly one outcome flag; it cannot be backpressured.
module cache_hierarchy #(
  parameter int ADDR_W   = 11,
  parameter int OFFSET_W = 2,
  parameter int L1_IDX_W = 3,
  parameter int L2_IDX_W = 5,
  parameter int L2_LAT   = 2,
  parameter int MEM_LAT  = 8,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              resp_valid,
  output logic              resp_l1_hit,
  output logic              resp_l2_hit,
  output logic              resp_miss,
  output logic [CNT_W-1:0]  l1_hit_cnt,
  output logic [CNT_W-1:0]  l2_hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [2:0]        dbg_state
);

  localparam int BLK_W    = ADDR_W - OFFSET_W;
  localparam int L1_TAG_W = BLK_W - L1_IDX_W;
  localparam int L2_TAG_W = BLK_W - L2_IDX_W;
  localparam int L1_LINES = 1 << L1_IDX_W;
  localparam int L2_LINES = 1 << L2_IDX_W;
  localparam int LAT_MAX  = (L2_LAT > MEM_LAT) ? L2_LAT : MEM_LAT;
  localparam int WAIT_W   = $clog2(LAT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_L1_CHK   = 3'd1,
    S_L2_WAIT  = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_RESP     = 3'd4
  } state_t;

  // Outcome encoding kept as one-hot {l1, l2, miss}
  localparam logic [2:0] OUT_L1   = 3'b100;
  localparam logic [2:0] OUT_L2   = 3'b010;
  localparam logic [2:0] OUT_MISS = 3'b001;

  state_t                state_q, state_d;
  logic [BLK_W-1:0]      blk_q, blk_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [2:0]            out_q, out_d;
  logic                  flush_pend_q, flush_pend_d;
  logic [L1_TAG_W-1:0]   l1_tag_q [L1_LINES];
  logic [L1_TAG_W-1:0]   l1_tag_d [L1_LINES];
  logic [L1_LINES-1:0]   l1_valid_q, l1_valid_d;
  logic [L2_TAG_W-1:0]   l2_tag_q [L2_LINES];
  logic [L2_TAG_W-1:0]   l2_tag_d [L2_LINES];
  logic [L2_LINES-1:0]   l2_valid_q, l2_valid_d;
  logic [CNT_W-1:0]      l1_cnt_q, l1_cnt_d;
  logic [CNT_W-1:0]      l2_cnt_q, l2_cnt_d;
  logic [CNT_W-1:0]      miss_cnt_q, miss_cnt_d;

  logic [L1_IDX_W-1:0]   l1_idx;
  logic [L1_TAG_W-1:0]   l1_tag;
  logic [L2_IDX_W-1:0]   l2_idx;
  logic [L2_TAG_W-1:0]   l2_tag;
  logic                  l1_hit;
  logic                  l2_hit;
  logic                  unused_offset;

  // Offset bits select a byte within the block and play no part in lookup
  assign unused_offset = ^req_addr[OFFSET_W-1:0];

  assign l1_idx = blk_q[L1_IDX_W-1:0];
  assign l1_tag = blk_q[BLK_W-1:L1_IDX_W];
  assign l2_idx = blk_q[L2_IDX_W-1:0];
  assign l2_tag = blk_q[BLK_W-1:L2_IDX_W];
  assign l1_hit = l1_valid_q[l1_idx] && (l1_tag_q[l1_idx] == l1_tag);
  assign l2_hit = l2_valid_q[l2_idx] && (l2_tag_q[l2_idx] == l2_tag);

  assign req_ready   = rst_n && (state_q == S_IDLE) && !flush && !flush_pend_q;
  assign resp_valid  = (state_q == S_RESP);
  assign resp_l1_hit = resp_valid && out_q[2];
  assign resp_l2_hit = resp_valid && out_q[1];
  assign resp_miss   = resp_valid && out_q[0];
  assign l1_hit_cnt  = l1_cnt_q;
  assign l2_hit_cnt  = l2_cnt_q;
  assign miss_cnt    = miss_cnt_q;
  assign dbg_state   = state_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Next-state, array update and counter logic
  always_comb begin
    state_d      = state_q;
    blk_d        = blk_q;
    wait_d       = wait_q;
    out_d        = out_q;
    flush_pend_d = flush_pend_q;
    l1_tag_d     = l1_tag_q;
    l1_valid_d   = l1_valid_q;
    l2_tag_d     = l2_tag_q;
    l2_valid_d   = l2_valid_q;
    l1_cnt_d     = l1_cnt_q;
    l2_cnt_d     = l2_cnt_q;
    miss_cnt_d   = miss_cnt_q;

    // A flush seen mid-request is remembered and executed back in IDLE
    if (flush && (state_q != S_IDLE)) flush_pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (flush || flush_pend_q) begin
          l1_valid_d   = '0;
          l2_valid_d   = '0;
          flush_pend_d = 1'b0;
        end else if (req_valid) begin
          blk_d   = req_addr[ADDR_W-1:OFFSET_W];
          state_d = S_L1_CHK;
        end
      end
      S_L1_CHK: begin
        if (l1_hit) begin
          out_d    = OUT_L1;
          l1_cnt_d = sat_inc(l1_cnt_q);
          state_d  = S_RESP;
        end else begin
          wait_d  = WAIT_W'(L2_LAT);
          state_d = S_L2_WAIT;
        end
      end
      S_L2_WAIT: begin
        if (wait_q == WAIT_W'(1)) begin
          if (l2_hit) begin
            // Promotion silently replaces whatever L1 held at this index
            l1_tag_d[l1_idx]   = l1_tag;
            l1_valid_d[l1_idx] = 1'b1;
            out_d              = OUT_L2;
            l2_cnt_d           = sat_inc(l2_cnt_q);
            state_d            = S_RESP;
          end else begin
            wait_d  = WAIT_W'(MEM_LAT);
            state_d = S_MEM_WAIT;
          end
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (wait_q == WAIT_W'(1)) begin
          l1_tag_d[l1_idx]   = l1_tag;
          l1_valid_d[l1_idx] = 1'b1;
          l2_tag_d[l2_idx]   = l2_tag;
          l2_valid_d[l2_idx] = 1'b1;
          out_d              = OUT_MISS;
          miss_cnt_d         = sat_inc(miss_cnt_q);
          state_d            = S_RESP;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, arrays and counters; reset abandons any in-flight request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      blk_q        <= '0;
      wait_q       <= '0;
      out_q        <= '0;
      flush_pend_q <= 1'b0;
      l1_valid_q   <= '0;
      l2_valid_q   <= '0;
      l1_cnt_q     <= '0;
      l2_cnt_q     <= '0;
      miss_cnt_q   <= '0;
      for (int i = 0; i < L1_LINES; i++) l1_tag_q[i] <= '0;
      for (int i = 0; i < L2_LINES; i++) l2_tag_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      blk_q        <= blk_d;
      wait_q       <= wait_d;
      out_q        <= out_d;
      flush_pend_q <= flush_pend_d;
      l1_valid_q   <= l1_valid_d;
      l2_valid_q   <= l2_valid_d;
      l1_cnt_q     <= l1_cnt_d;
      l2_cnt_q     <= l2_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      l1_tag_q     <= l1_tag_d;
      l2_tag_q     <= l2_tag_d;
    end
  end

endmodule

// File: tb/tb_cache_hierarchy.sv
// Directed bench for cache_hierarchy: latency per level, promotion, flush in
// IDLE and mid-request, counter saturation (second instance with CNT_W=2)
// and reset asserted during a miss.
module tb_cache_hierarchy;

  localparam logic [2:0] K_L1   = 3'b100;
  localparam logic [2:0] K_L2   = 3'b010;
  localparam logic [2:0] K_MISS = 3'b001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [10:0] req_addr = '0;
  logic        flush = 1'b0;

  logic        req_ready, resp_valid, resp_l1_hit, resp_l2_hit, resp_miss;
  logic [15:0] l1_hit_cnt, l2_hit_cnt, miss_cnt;
  logic [2:0]  dbg_state;

  logic        s_req_ready, s_resp_valid, s_resp_l1_hit, s_resp_l2_hit, s_resp_miss;
  logic [1:0]  s_l1_hit_cnt, s_l2_hit_cnt, s_miss_cnt;
  logic [2:0]  s_dbg_state;

  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [2:0]  exp_q[$];

  cache_hierarchy dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .flush(flush), .resp_valid(resp_valid),
    .resp_l1_hit(resp_l1_hit), .resp_l2_hit(resp_l2_hit), .resp_miss(resp_miss),
    .l1_hit_cnt(l1_hit_cnt), .l2_hit_cnt(l2_hit_cnt), .miss_cnt(miss_cnt),
    .dbg_state(dbg_state)
  );

  cache_hierarchy #(.CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_addr(req_addr), .flush(flush), .resp_valid(s_resp_valid),
    .resp_l1_hit(s_resp_l1_hit), .resp_l2_hit(s_resp_l2_hit), .resp_miss(s_resp_miss),
    .l1_hit_cnt(s_l1_hit_cnt), .l2_hit_cnt(s_l2_hit_cnt), .miss_cnt(s_miss_cnt),
    .dbg_state(s_dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog so the run always ends
  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for ready, present the request, return #1 after the accepting edge
  task automatic start_req(input logic [10:0] addr, input logic [2:0] kind);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    exp_q.push_back(kind);
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for the response strobe and score it against exp_q
  task automatic wait_resp(input string tag, input int exp_lat);
    int         n = 0;
    bit         seen = 1'b0;
    logic [2:0] exp_k;
    while (n < 40 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      if (resp_valid) seen = 1'b1;
    end
    check({tag, "_seen"}, {31'd0, seen}, 32'd1);
    exp_k = exp_q.pop_front();
    if (seen) begin
      check({tag, "_kind"}, {29'd0, resp_l1_hit, resp_l2_hit, resp_miss}, {29'd0, exp_k});
      check({tag, "_lat"}, cyc - acc_cyc, exp_lat);
    end
  endtask

  task automatic do_req(input string tag, input logic [10:0] addr,
                        input logic [2:0] kind, input int exp_lat);
    start_req(addr, kind);
    wait_resp(tag, exp_lat);
  endtask

  initial begin
    bit any_resp;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp", {28'd0, resp_valid, resp_l1_hit, resp_l2_hit, resp_miss}, 32'd0);
    check("rst_cnt_l1", l1_hit_cnt, 32'd0);
    check("rst_cnt_l2", l2_hit_cnt, 32'd0);
    check("rst_cnt_miss", miss_cnt, 32'd0);
    check("rst_state", dbg_state, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // Cold miss then same-block L1 hit
    do_req("cold_004", 11'h004, K_MISS, 11);
    @(posedge clk);
    #1;
    check("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
    check("miss_cnt_1", miss_cnt, 32'd1);
    do_req("hit_005", 11'h005, K_L1, 1);
    check("l1_cnt_1", l1_hit_cnt, 32'd1);

    // L1 conflict evicts 0x004; it returns from L2 and is promoted
    do_req("hit_004", 11'h004, K_L1, 1);
    do_req("miss_024", 11'h024, K_MISS, 11);
    do_req("l2_004", 11'h004, K_L2, 3);
    check("l2_cnt_1", l2_hit_cnt, 32'd1);
    do_req("promo_004", 11'h004, K_L1, 1);
    check("l1_cnt_3", l1_hit_cnt, 32'd3);
    check("miss_cnt_2", miss_cnt, 32'd2);

    // Flush in IDLE
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_idle_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("after_flush_ready", {31'd0, req_ready}, 32'd1);
    do_req("post_flush_004", 11'h004, K_MISS, 11);
    check("pf_miss_cnt", miss_cnt, 32'd3);
    check("pf_l1_cnt", l1_hit_cnt, 32'd3);
    check("pf_l2_cnt", l2_hit_cnt, 32'd1);

    // Flush pulsed during MEM_WAIT
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    start_req(11'h004, K_MISS);
    repeat (4) @(posedge clk);
    #1;
    check("in_mem_wait", dbg_state, 32'd3);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    wait_resp("flush_mid", 11);
    @(posedge clk);
    #1;
    check("pend_ready_low", {31'd0, req_ready}, 32'd0);
    check("pend_idle", dbg_state, 32'd0);
    @(posedge clk);
    #1;
    check("pend_ready_back", {31'd0, req_ready}, 32'd1);
    do_req("after_pend_004", 11'h004, K_MISS, 11);
    check("fm_miss_cnt", miss_cnt, 32'd5);

    // Reset five cycles into a miss
    start_req(11'h040, K_MISS);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_resp", {31'd0, resp_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    check("mid_rst_state", dbg_state, 32'd0);
    check("mid_rst_cnts", {l1_hit_cnt, l2_hit_cnt} | {16'd0, miss_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    any_resp = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (resp_valid) any_resp = 1'b1;
    end
    check("abandoned_no_resp", {31'd0, any_resp}, 32'd0);
    check("abandoned_miss_cnt", miss_cnt, 32'd0);
    do_req("rerun_040", 11'h040, K_MISS, 11);
    check("rerun_miss_cnt", miss_cnt, 32'd1);

    // Saturation on the CNT_W=2 instance
    repeat (5) do_req("sat_hit_040", 11'h040, K_L1, 1);
    check("wide_l1_cnt_5", l1_hit_cnt, 32'd5);
    check("sat_l1_cnt_3", {30'd0, s_l1_hit_cnt}, 32'd3);
    check("sat_miss_cnt_1", {30'd0, s_miss_cnt}, 32'd1);
    check("sat_l2_cnt_0", {30'd0, s_l2_hit_cnt}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_hierarchy.md
# cache_hierarchy

Parametrised two-level direct-mapped cache lookup controller. It owns the L1 and L2 tag/valid arrays and serves one address request at a time over a valid/ready handshake. It reports L1 hit, L2 hit or memory miss with level-accurate latency, performs real L2-to-L1 promotion and fill-on-miss, supports a whole-cache flush, and keeps saturating per-outcome counters. It sits between the address-trace driver and the statistics/report logic of the simulator.

## Interface
- ADDR_W, 11, request address width
- OFFSET_W, 2, block offset bits (ignored for lookup)
- L1_IDX_W, 3, log2 L1 lines; must be <= L2_IDX_W
- L2_IDX_W, 5, log2 L2 lines; OFFSET_W+L2_IDX_W < ADDR_W
- L2_LAT, 2, L2 access cycles, >= 1
- MEM_LAT, 8, memory access cycles, >= 1
- CNT_W, 16, width of each statistics counter

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  ready to accept a request
- req_addr  in  ADDR_W  request address, sampled on the accepting edge
- flush  in  1  invalidate all L1 and L2 lines
- resp_valid  out  1  one-cycle response strobe
- resp_l1_hit, resp_l2_hit, resp_miss  out  1 each  outcome; exactly one is high when resp_valid=1, all are 0 otherwise
- l1_hit_cnt, l2_hit_cnt, miss_cnt  out  CNT_W each  saturating outcome counters

## Operation
- Block address = req_addr[ADDR_W-1:OFFSET_W].
  - Lx index = low Lx_IDX_W bits of the block address.
  - Lx tag = the remaining upper bits.
  - Each line holds a tag and a valid bit.
- States: IDLE, L1_CHK, L2_WAIT, MEM_WAIT, RESP.
- req_ready = rst_n && state==IDLE && !flush && !flush_pend.
- Request acceptance:
  - Accept on an edge where req_valid && req_ready.
  - Capture the address and go to L1_CHK.
- L1_CHK (one cycle):
  - On an L1 hit (valid && tag match): go to RESP with outcome l1.
  - Otherwise: load the wait counter with L2_LAT and go to L2_WAIT.
- L2_WAIT:
  - Decrement the wait counter each edge.
  - On the edge where the counter is 1, check L2.
  - L2 hit: write the L1 line (tag, valid=1) on that same edge (promotion; the old L1 line is overwritten silently), then go to RESP with outcome l2.
  - L2 miss: load the wait counter with MEM_LAT and go to MEM_WAIT.
- MEM_WAIT:
  - On the final edge, fill both the L1 and L2 lines (tag, valid=1).
  - Go to RESP with outcome miss.
- RESP:
  - resp_valid and the outcome flag are high for exactly one cycle.
  - The matching counter increments on the edge that enters RESP and saturates at all-ones.
  - Next state is IDLE.
- Flush:
  - If flush is high in IDLE, all valid bits clear on that edge. flush takes priority over req_valid, and no request is accepted on that edge.
  - If flush is high while not in IDLE, set flush_pend. The in-flight request completes normally, including its fill. The flush executes on the first IDLE edge and clears flush_pend.
  - Flush does not clear the counters.
- Responses cannot be backpressured.

## Timing
- Latency, measured from the accepting edge to the edge that raises resp_valid:
  - L1 hit: 1
  - L2 hit: 1+L2_LAT (3 with default parameters)
  - miss: 1+L2_LAT+MEM_LAT (11 with default parameters)
- req_ready rises in the cycle after RESP, so there is a minimum of 1 idle cycle between requests.
- Reset values:
  - state IDLE
  - all valid bits 0
  - resp_* 0
  - counters 0
  - flush_pend 0
  - req_ready 0 while rst_n is low, 1 on the first cycle after release (if flush is low)
- Reset asserted mid-operation:
  - The request is abandoned immediately.
  - No response is issued and no counter is updated.
  - A fill not yet written is lost.
- Array writes (promotion/fill) and flush never coincide, because flush executes only in IDLE.

## Test plan
- Reset, then request 0x004 → miss at 11 cycles, miss_cnt=1. Then request 0x005 (same block) → resp_l1_hit at 1 cycle, l1_hit_cnt=1.
- Requests 0x004, then 0x024 (same L1 index 1, different L2 index), then 0x004 → third response is resp_l2_hit at 3 cycles. A fourth request to 0x004 → resp_l1_hit (promotion verified).
- After filling 0x004, pulse flush in IDLE → req_ready=0 that cycle. Request 0x004 → resp_miss, counters unchanged except miss_cnt+1.
- Pulse flush during MEM_WAIT of 0x004 → miss response at 11 cycles, req_ready held 0 for the one flush cycle. Request 0x004 → miss again.
- With CNT_W=2: one miss, then five hits to the same block → l1_hit_cnt=3 (saturated), miss_cnt=1.
- Assert rst_n low 5 cycles into a miss → resp_valid never rises, all counters 0. Request the same address after release → miss.
